// File: rtl/slice_serial_add_sub_if.sv
// Request/result bundle for the slice-serial adder/subtractor.
// The requester drives the master side; the arithmetic block is the slave.
interface slice_serial_add_sub_if #(
  parameter int N = 16
);
  logic         start;
  logic         op;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic         busy;
  logic         done;
  logic [N-1:0] S;
  logic         Cout;
  logic         ovf;

  modport master (
    output start, op, A, B, Cin,
    input  busy, done, S, Cout, ovf
  );

  modport slave (
    input  start, op, A, B, Cin,
    output busy, done, S, Cout, ovf
  );
endinterface

// File: rtl/slice_serial_add_sub.sv
// N-bit add/subtract computed K bits per clock, rippling the carry through a register.
// Subtraction is A + ~B + ~Cin; borrow-out is the inverted final carry.
module slice_serial_add_sub #(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  slice_serial_add_sub_if.slave bus
);
  localparam int SLICES = N / K;
  localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_next;
  logic [N-1:0]   a_q, b_q, res_q, res_next;
  logic [CW-1:0]  idx_q;
  logic           carry_q, op_q, a_msb_q, b_msb_q;
  logic [N-1:0]   s_q;
  logic           cout_q, ovf_q;
  logic [K:0]     slice_sum;
  logic           accept, last;

  assign accept    = bus.start && (state != RUN);
  assign last      = (idx_q == CW'(SLICES - 1));
  assign slice_sum = {1'b0, a_q[K-1:0]} + {1'b0, b_q[K-1:0]} + (K+1)'(carry_q);
  // New slice enters at the top; after SLICES shifts the result sits in place.
  assign res_next  = N'({slice_sum[K-1:0], res_q} >> K);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    state_next = bus.start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.A;
      b_q     <= bus.op ? ~bus.B : bus.B;
      carry_q <= bus.op ? ~bus.Cin : bus.Cin;
      op_q    <= bus.op;
      a_msb_q <= bus.A[N-1];
      b_msb_q <= bus.op ? ~bus.B[N-1] : bus.B[N-1];
      idx_q   <= '0;
    end else if (state == RUN) begin
      a_q     <= a_q >> K;
      b_q     <= b_q >> K;
      carry_q <= slice_sum[K];
      res_q   <= res_next;
      idx_q   <= idx_q + 1'b1;
      if (last) begin
        s_q    <= res_next;
        cout_q <= op_q ^ slice_sum[K];
        ovf_q  <= (a_msb_q == b_msb_q) && (res_next[N-1] != a_msb_q);
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.S    = s_q;
  assign bus.Cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_slice_serial_add_sub.sv
// Self-checking bench: transaction-level model (latency + integer arithmetic)
// compared every cycle, plus directed cases with hand-computed results.
module tb_slice_serial_add_sub;
  localparam int N = 16;
  localparam int K = 4;
  localparam int L = N / K;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  bit   chk_en = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  slice_serial_add_sub_if #(.N(N)) bus ();

  slice_serial_add_sub #(.N(N), .K(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result computed with plain integer arithmetic: {ovf, Cout, S}
  function automatic logic [N+1:0] ref_calc(bit op, logic [N-1:0] a, logic [N-1:0] b, bit cin);
    longint ua, ub, r, sa, sb, sr;
    logic [N-1:0] s;
    bit c, v;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!op) begin
      r  = ua + ub + cin;
      c  = (r > ((64'sd1 << N) - 1));
      sr = sa + sb + cin;
    end else begin
      r  = ua - ub - cin;
      c  = (ua < ub + cin);
      sr = sa - sb - cin;
    end
    s = r[N-1:0];
    v = (sr > ((64'sd1 << (N-1)) - 1)) || (sr < -(64'sd1 << (N-1)));
    return {v, c, s};
  endfunction

  // Model: one transaction at a time, result appears L edges after accept
  bit           m_busy, m_done, m_cout, m_ovf;
  logic [N-1:0] m_s;
  logic [N+1:0] m_pend;
  int           m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_cout = 0; m_ovf = 0; m_s = '0; m_cnt = 0; m_pend = '0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0;
          m_done = 1;
          {m_ovf, m_cout, m_s} = m_pend;
        end
      end else if (bus.start) begin
        m_busy = 1;
        m_cnt  = L;
        m_pend = ref_calc(bus.op, bus.A, bus.B, bus.Cin);
      end
    end
  end

  always begin
    @(negedge clk);
    #1;
    if (chk_en) begin
      check("cyc_busy", 32'(bus.busy), 32'(m_busy));
      check("cyc_done", 32'(bus.done), 32'(m_done));
      check("cyc_S",    32'(bus.S),    32'(m_s));
      check("cyc_Cout", 32'(bus.Cout), 32'(m_cout));
      check("cyc_ovf",  32'(bus.ovf),  32'(m_ovf));
    end
  end

  // Starts at a negedge, returns at the negedge where done is high
  task automatic run_op(bit op, logic [N-1:0] a, logic [N-1:0] b, bit cin, bit lit,
                        logic [N-1:0] es, bit ec, bit ev, bit poke);
    int cnt, busy_cnt;
    bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b; bus.Cin = cin;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = N'($urandom); bus.B = N'($urandom);
    bus.op = 1'($urandom); bus.Cin = 1'($urandom);
    cnt = 0;
    busy_cnt = 0;
    while (!bus.done && cnt < 20) begin
      if (bus.busy) busy_cnt++;
      if (poke && cnt == 1) begin
        bus.start = 1'b1;
        bus.A = 16'hAAAA;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    bus.start = 1'b0;
    check("latency", 32'(cnt), 32'(L));
    if (lit) begin
      check("busy_cycles", 32'(busy_cnt), 32'(L));
      check("lit_S",    32'(bus.S),    32'(es));
      check("lit_Cout", 32'(bus.Cout), 32'(ec));
      check("lit_ovf",  32'(bus.ovf),  32'(ev));
    end
  endtask

  function automatic logic [N-1:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return N'($urandom);
    endcase
  endfunction

  initial begin
    bit seen;
    bus.start = 1'b0; bus.op = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_S",    32'(bus.S),    0);
    check("rst_Cout", 32'(bus.Cout), 0);
    check("rst_ovf",  32'(bus.ovf),  0);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(0, 16'h1234, 16'h0FFF, 0, 1, 16'h2233, 0, 0, 0);
    run_op(0, 16'hFFFF, 16'h0001, 0, 1, 16'h0000, 1, 0, 0);
    run_op(1, 16'h0005, 16'h0007, 0, 1, 16'hFFFE, 1, 0, 0);
    run_op(1, 16'h0010, 16'h0001, 1, 1, 16'h000E, 0, 0, 0);
    run_op(1, 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 0, 1, 0);
    run_op(0, 16'h7FFF, 16'h0000, 1, 1, 16'h8000, 0, 1, 0);
    @(negedge clk);

    // start during RUN ignored, then back-to-back accept in the DONE cycle
    run_op(0, 16'h0001, 16'h0001, 0, 1, 16'h0002, 0, 0, 1);
    run_op(1, 16'h1000, 16'h0001, 0, 1, 16'h0FFF, 0, 0, 0);
    @(negedge clk);

    // Reset two cycles after accept abandons the operation
    bus.start = 1'b1; bus.op = 1'b0; bus.A = 16'h1234; bus.B = 16'h1111; bus.Cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_done", 32'(bus.done), 0);
    check("midrst_S",    32'(bus.S),    0);
    check("midrst_Cout", 32'(bus.Cout), 0);
    check("midrst_ovf",  32'(bus.ovf),  0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("no_done_after_rst", 32'(seen), 0);
    run_op(0, 16'h4321, 16'h1111, 1, 1, 16'h5433, 0, 0, 0);

    // Randomized traffic checked by the per-cycle model
    repeat (40) begin
      if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      run_op(1'($urandom), pick_val(), pick_val(), 1'($urandom), 0, '0, 0, 0, 1'($urandom));
    end
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
